// File: rtl/filter_frame_ctrl.sv
// rtl/filter_frame_ctrl.sv - frame-synchronous config shadowing, lit-pixel counter, optional auto-threshold
//
// Host writes land in shadow registers and reach Display/Threshold only in the
// single S_UPDATE cycle after a VSync rising edge, so neither ever changes
// mid-frame. Lit pixels (VDE & BinIn) are counted per frame with saturation.
//
// Optional feature macro: AUTO_THRESH_EN (Target/Control registers and the
// per-frame threshold servo). Without it, addr 2/3 writes are accepted and dropped.
//
// Ports:
//   CLK, RST_N            pixel clock, asynchronous active-low reset
//   VSync, VDE, BinIn     video timing and first-stage binary pixel
//   CfgValid/CfgReady     host write handshake; CfgAddr selects register,
//                         CfgData is LSB-aligned write data (CNT_W bits)
//   Display, Threshold    applied configuration
//   PixelCount            lit-pixel count of last completed frame
//   FrameCount            completed-frame counter (wraps)
//   FrameDone             one-cycle pulse when PixelCount/FrameCount update

module filter_frame_ctrl #(
  parameter int         CNT_W       = 24,
  parameter int         STEP        = 4,
  parameter int         TOL         = 1024,
  parameter logic [5:0] DISPLAY_RST = 6'h00,
  parameter logic [7:0] THRESH_RST  = 8'h80
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VSync,
  input  logic             VDE,
  input  logic             BinIn,
  input  logic             CfgValid,
  output logic             CfgReady,
  input  logic [1:0]       CfgAddr,
  input  logic [CNT_W-1:0] CfgData,
  output logic [5:0]       Display,
  output logic [7:0]       Threshold,
  output logic [CNT_W-1:0] PixelCount,
  output logic [15:0]      FrameCount,
  output logic             FrameDone
);

  typedef enum logic [1:0] {S_SYNC, S_FRAME, S_UPDATE} state_t;

  state_t state_q, state_d;
  logic   vsync_q, vsync_d;
  logic   first_q, first_d;
  logic   cfg_ready_q, cfg_ready_d;
  logic   fd_q, fd_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [15:0]      fc_q, fc_d;

  logic [5:0] disp_q, disp_d, disp_sh_q, disp_sh_d;
  logic       disp_pend_q, disp_pend_d;
  logic [7:0] thr_q, thr_d, thr_sh_q, thr_sh_d;
  logic       thr_pend_q, thr_pend_d;

  logic vsync_rise;
  logic wr_en;
  logic cfg_unused;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign vsync_rise = VSync & ~vsync_q;
  assign wr_en      = CfgValid & cfg_ready_q;
  // Register fields narrower than CfgData simply ignore the upper bits.
  assign cfg_unused = ^CfgData;

`ifdef AUTO_THRESH_EN
  // Wide enough for counter + TOL and Target + TOL without overflow.
  localparam int SW = (CNT_W + 1 > 32) ? CNT_W + 1 : 32;

  logic [CNT_W-1:0] target_q, target_d;
  logic             auto_q, auto_d;
  logic [SW-1:0]    cnt_ext, tgt_ext, tol_ext;
  logic [8:0]       thr_up;
  logic [7:0]       thr_dn;

  assign cnt_ext = SW'(cnt_q);
  assign tgt_ext = SW'(target_q);
  assign tol_ext = SW'(TOL);
  assign thr_up  = {1'b0, thr_q} + 9'(STEP);
  assign thr_dn  = (thr_q < 8'(STEP)) ? 8'h00 : thr_q - 8'(STEP);
`endif

  always_comb begin
    state_d     = state_q;
    vsync_d     = VSync;
    first_d     = first_q;
    fd_d        = 1'b0;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    fc_d        = fc_q;
    disp_d      = disp_q;
    disp_sh_d   = disp_sh_q;
    disp_pend_d = disp_pend_q;
    thr_d       = thr_q;
    thr_sh_d    = thr_sh_q;
    thr_pend_d  = thr_pend_q;
`ifdef AUTO_THRESH_EN
    target_d    = target_q;
    auto_d      = auto_q;
`endif

    if (wr_en) begin
      case (CfgAddr)
        2'd0: begin
          disp_sh_d   = CfgData[5:0];
          disp_pend_d = 1'b1;
        end
        2'd1: begin
          thr_sh_d   = CfgData[7:0];
          thr_pend_d = 1'b1;
        end
`ifdef AUTO_THRESH_EN
        2'd2:    target_d = CfgData;
        default: auto_d   = CfgData[0];
`else
        default: ;
`endif
      endcase
    end

    case (state_q)
      S_SYNC: begin
        if (vsync_rise) begin
          state_d = S_UPDATE;
          first_d = 1'b1;
        end
      end
      S_FRAME: begin
        if (VDE && BinIn && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
        if (vsync_rise) begin
          state_d = S_UPDATE;
          first_d = 1'b0;
        end
      end
      S_UPDATE: begin
        state_d = S_FRAME;
        cnt_d   = '0;
        if (!first_q) begin
          pix_d = cnt_q;
          fc_d  = fc_q + 16'd1;
          fd_d  = 1'b1;
        end
        if (disp_pend_q) begin
          disp_d      = disp_sh_q;
          disp_pend_d = 1'b0;
        end
        if (thr_pend_q) begin
          // A manual write always beats the servo for this frame.
          thr_d      = thr_sh_q;
          thr_pend_d = 1'b0;
        end
`ifdef AUTO_THRESH_EN
        else if (!first_q && auto_q) begin
          if (cnt_ext > tgt_ext + tol_ext)
            thr_d = thr_up[8] ? 8'hFF : thr_up[7:0];
          else if (cnt_ext + tol_ext < tgt_ext)
            thr_d = thr_dn;
        end
`endif
      end
      default: state_d = S_SYNC;
    endcase

    // Ready is registered so it reads low throughout S_UPDATE and in reset.
    cfg_ready_d = (state_d != S_UPDATE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_SYNC;
      vsync_q     <= 1'b0;
      first_q     <= 1'b1;
      cfg_ready_q <= 1'b0;
      fd_q        <= 1'b0;
      cnt_q       <= '0;
      pix_q       <= '0;
      fc_q        <= 16'd0;
      disp_q      <= DISPLAY_RST;
      disp_sh_q   <= 6'd0;
      disp_pend_q <= 1'b0;
      thr_q       <= THRESH_RST;
      thr_sh_q    <= 8'd0;
      thr_pend_q  <= 1'b0;
`ifdef AUTO_THRESH_EN
      target_q    <= '0;
      auto_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      first_q     <= first_d;
      cfg_ready_q <= cfg_ready_d;
      fd_q        <= fd_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      fc_q        <= fc_d;
      disp_q      <= disp_d;
      disp_sh_q   <= disp_sh_d;
      disp_pend_q <= disp_pend_d;
      thr_q       <= thr_d;
      thr_sh_q    <= thr_sh_d;
      thr_pend_q  <= thr_pend_d;
`ifdef AUTO_THRESH_EN
      target_q    <= target_d;
      auto_q      <= auto_d;
`endif
    end
  end

  assign CfgReady   = cfg_ready_q;
  assign Display    = disp_q;
  assign Threshold  = thr_q;
  assign PixelCount = pix_q;
  assign FrameCount = fc_q;
  assign FrameDone  = fd_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// tb/tb_filter_frame_ctrl.sv - self-checking bench for filter_frame_ctrl

module tb_filter_frame_ctrl;

  localparam int STEP = 4;
  localparam int TOL  = 1024;
  localparam int MAX24 = 24'hFFFFFF;

  logic        CLK = 1'b0;
  logic        RST_N, VSync, VDE, BinIn, CfgValid;
  logic [1:0]  CfgAddr;
  logic [23:0] CfgData;
  logic        CfgReady, FrameDone;
  logic [5:0]  Display;
  logic [7:0]  Threshold;
  logic [23:0] PixelCount;
  logic [15:0] FrameCount;

  logic [7:0]  cfg_data8;
  logic        r8, fd8;
  logic [5:0]  disp8;
  logic [7:0]  thr8, pix8;
  logic [15:0] fc8;

  assign cfg_data8 = CfgData[7:0];

  filter_frame_ctrl u_dut (
    .CLK(CLK), .RST_N(RST_N), .VSync(VSync), .VDE(VDE), .BinIn(BinIn),
    .CfgValid(CfgValid), .CfgReady(CfgReady), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .Display(Display), .Threshold(Threshold), .PixelCount(PixelCount),
    .FrameCount(FrameCount), .FrameDone(FrameDone)
  );

  filter_frame_ctrl #(.CNT_W(8)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .VSync(VSync), .VDE(VDE), .BinIn(BinIn),
    .CfgValid(CfgValid), .CfgReady(r8), .CfgAddr(CfgAddr), .CfgData(cfg_data8),
    .Display(disp8), .Threshold(thr8), .PixelCount(pix8),
    .FrameCount(fc8), .FrameDone(fd8)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state described by the register rules.
  int m_disp, m_thr, m_disp_sh, m_thr_sh, m_pix, m_pix8, m_fc, lit, m_target;
  bit m_dp, m_tp, m_first, m_auto;

  task automatic model_reset();
    m_disp = 0; m_thr = 8'h80; m_pix = 0; m_pix8 = 0; m_fc = 0; lit = 0;
    m_dp = 0; m_tp = 0; m_first = 1; m_target = 0; m_auto = 0;
  endtask

  task automatic model_update(output int exp_fd);
    int c;
    exp_fd = m_first ? 0 : 1;
    if (!m_first) begin
      c = (lit > MAX24) ? MAX24 : lit;
      m_pix  = c;
      m_pix8 = (lit > 255) ? 255 : lit;
      m_fc   = (m_fc + 1) % 65536;
`ifdef AUTO_THRESH_EN
      if (m_auto && !m_tp) begin
        if (c > m_target + TOL)      m_thr = (m_thr + STEP > 255) ? 255 : m_thr + STEP;
        else if (c + TOL < m_target) m_thr = (m_thr < STEP) ? 0 : m_thr - STEP;
      end
`endif
    end
    if (m_dp) m_disp = m_disp_sh;
    if (m_tp) m_thr = m_thr_sh;
    m_dp = 0; m_tp = 0; m_first = 0; lit = 0;
  endtask

  // mode 0: random VDE/BinIn, 1: VDE=1 with BinIn every other cycle, 2: all lit
  task automatic frame(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      case (mode)
        0:       begin VDE = 1'($urandom); BinIn = 1'($urandom); end
        1:       begin VDE = 1'b1; BinIn = 1'(i % 2); end
        default: begin VDE = 1'b1; BinIn = 1'b1; end
      endcase
      if (VDE && BinIn) lit++;
    end
    @(negedge CLK);
    VDE = 1'b0; BinIn = 1'b0;
    checks++;
    if (Threshold !== 8'(m_thr)) begin
      errors++; $display("FAIL mid_frame_thr got %0h exp %0h", Threshold, 8'(m_thr));
    end
    checks++;
    if (Display !== 6'(m_disp)) begin
      errors++; $display("FAIL mid_frame_disp got %0h exp %0h", Display, 6'(m_disp));
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [23:0] d);
    bit ok, rdy;
    @(negedge CLK);
    CfgValid = 1'b1; CfgAddr = a; CfgData = d; VDE = 1'b1; BinIn = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = CfgReady;
      @(posedge CLK);
      if (rdy) begin ok = 1; break; end
      @(negedge CLK);
    end
    @(negedge CLK);
    CfgValid = 1'b0; VDE = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL cfg_accept_timeout got ready=0 exp ready=1 within 20 cycles");
    end else begin
      case (a)
        2'd0: begin m_disp_sh = int'(d[5:0]); m_dp = 1; end
        2'd1: begin m_thr_sh = int'(d[7:0]); m_tp = 1; end
`ifdef AUTO_THRESH_EN
        2'd2: m_target = int'(d);
        default: m_auto = d[0];
`else
        default: ;
`endif
      endcase
    end
  endtask

  task automatic vsync_pulse();
    int exp_fd;
    @(negedge CLK);
    VSync = 1'b1; VDE = 1'b0; BinIn = 1'b0;
    @(negedge CLK);
    checks++;
    if (CfgReady !== 1'b0) begin errors++; $display("FAIL upd_ready got %0b exp 0", CfgReady); end
    checks++;
    if (Threshold !== 8'(m_thr)) begin
      errors++; $display("FAIL thr_latency got %0h exp %0h", Threshold, 8'(m_thr));
    end
    checks++;
    if (FrameDone !== 1'b0) begin errors++; $display("FAIL fd_early got %0b exp 0", FrameDone); end
    model_update(exp_fd);
    @(negedge CLK);
    VSync = 1'b0;
    checks++;
    if (Display !== 6'(m_disp)) begin errors++; $display("FAIL disp_apply got %0h exp %0h", Display, 6'(m_disp)); end
    checks++;
    if (Threshold !== 8'(m_thr)) begin errors++; $display("FAIL thr_apply got %0h exp %0h", Threshold, 8'(m_thr)); end
    checks++;
    if (PixelCount !== 24'(m_pix)) begin errors++; $display("FAIL pix_count got %0d exp %0d", PixelCount, m_pix); end
    checks++;
    if (pix8 !== 8'(m_pix8)) begin errors++; $display("FAIL pix_count8 got %0d exp %0d", pix8, m_pix8); end
    checks++;
    if (FrameCount !== 16'(m_fc)) begin errors++; $display("FAIL frame_count got %0d exp %0d", FrameCount, m_fc); end
    checks++;
    if (FrameDone !== 1'(exp_fd)) begin errors++; $display("FAIL frame_done got %0b exp %0d", FrameDone, exp_fd); end
    @(negedge CLK);
    checks++;
    if (FrameDone !== 1'b0) begin errors++; $display("FAIL fd_one_cycle got %0b exp 0", FrameDone); end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; VSync = 0; VDE = 0; BinIn = 0; CfgValid = 0; CfgAddr = 0; CfgData = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (Display !== 6'h00 || Threshold !== 8'h80) begin
      errors++; $display("FAIL reset_cfg got %0h/%0h exp 00/80", Display, Threshold);
    end
    checks++;
    if (PixelCount !== 24'd0 || FrameCount !== 16'd0 || FrameDone !== 1'b0 || CfgReady !== 1'b0) begin
      errors++; $display("FAIL reset_stat got %0d/%0d/%0b/%0b exp 0/0/0/0", PixelCount, FrameCount, FrameDone, CfgReady);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_no_writes();
    frame(20, 0); vsync_pulse();
    frame(60, 0); vsync_pulse();
    frame(60, 0); vsync_pulse();
    checks++;
    if (FrameCount !== 16'd2 || Display !== 6'h00 || Threshold !== 8'h80) begin
      errors++; $display("FAIL three_frames got fc=%0d d=%0h t=%0h exp 2/00/80", FrameCount, Display, Threshold);
    end
  endtask

  task automatic test_cfg_write();
    frame(50, 0);
    cfg_write(2'd1, 24'hFFFF40);
    frame(50, 0);
    vsync_pulse();
    checks++;
    if (Threshold !== 8'h40) begin errors++; $display("FAIL thr_40 got %0h exp 40", Threshold); end
    frame(30, 0);
    cfg_write(2'd1, 24'h000040);
    frame(30, 0);
    cfg_write(2'd1, 24'h000050);
    cfg_write(2'd0, 24'hABCD15);
    frame(30, 0);
    vsync_pulse();
    checks++;
    if (Threshold !== 8'h50 || Display !== 6'h15) begin
      errors++; $display("FAIL last_wins got %0h/%0h exp 50/15", Threshold, Display);
    end
  endtask

  task automatic test_pixel_count();
    frame(5000, 1);
    vsync_pulse();
    checks++;
    if (PixelCount !== 24'd2500 || pix8 !== 8'd255) begin
      errors++; $display("FAIL pix_2500 got %0d/%0d exp 2500/255", PixelCount, pix8);
    end
    frame(300, 2);
    vsync_pulse();
  endtask

  task automatic test_held_across_update();
    int exp_fd;
    frame(40, 0);
    @(negedge CLK);
    VSync = 1'b1;
    @(negedge CLK);
    CfgValid = 1'b1; CfgAddr = 2'd1; CfgData = 24'h000033;
    checks++;
    if (CfgReady !== 1'b0) begin errors++; $display("FAIL held_ready_upd got %0b exp 0", CfgReady); end
    model_update(exp_fd);
    @(negedge CLK);
    VSync = 1'b0;
    checks++;
    if (CfgReady !== 1'b1 || Threshold !== 8'(m_thr) || FrameDone !== 1'(exp_fd)) begin
      errors++; $display("FAIL held_next got r=%0b t=%0h fd=%0b exp 1/%0h/%0d", CfgReady, Threshold, FrameDone, 8'(m_thr), exp_fd);
    end
    @(posedge CLK);
    m_thr_sh = 8'h33; m_tp = 1;
    @(negedge CLK);
    CfgValid = 1'b0;
    frame(40, 0);
    vsync_pulse();
    checks++;
    if (Threshold !== 8'h33) begin errors++; $display("FAIL held_applied got %0h exp 33", Threshold); end
  endtask

`ifdef AUTO_THRESH_EN
  task automatic test_auto();
    cfg_write(2'd2, 24'd1000);
    cfg_write(2'd3, 24'd1);
    cfg_write(2'd1, 24'h80);
    frame(10, 0); vsync_pulse();
    frame(3000, 2); vsync_pulse();
    checks++;
    if (Threshold !== 8'h84) begin errors++; $display("FAIL auto_up got %0h exp 84", Threshold); end
    frame(500, 2); vsync_pulse();
    cfg_write(2'd1, 24'hFE);
    frame(10, 0); vsync_pulse();
    frame(3000, 2); vsync_pulse();
    frame(3000, 2); vsync_pulse();
    checks++;
    if (Threshold !== 8'hFF) begin errors++; $display("FAIL auto_sat got %0h exp ff", Threshold); end
    cfg_write(2'd3, 24'd0);
  endtask
`endif

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      frame(int'($urandom_range(20, 300)), 0);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        cfg_write(2'($urandom_range(0, 3)), 24'($urandom));
        frame(int'($urandom_range(5, 100)), 0);
      end
      vsync_pulse();
    end
  endtask

  task automatic test_reset_midframe();
    cfg_write(2'd0, 24'h15);
    frame(10, 0); vsync_pulse();
    frame(100, 2);
    cfg_write(2'd0, 24'h2A);
    frame(40, 0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if (Display !== 6'h00 || Threshold !== 8'h80 || PixelCount !== 24'd0 || FrameCount !== 16'd0
        || FrameDone !== 1'b0 || CfgReady !== 1'b0) begin
      errors++; $display("FAIL async_reset got d=%0h t=%0h p=%0d fc=%0d fd=%0b r=%0b exp 00/80/0/0/0/0",
                         Display, Threshold, PixelCount, FrameCount, FrameDone, CfgReady);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    frame(30, 0);
    vsync_pulse();
    checks++;
    if (Display !== 6'h00) begin errors++; $display("FAIL pending_discard got %0h exp 00", Display); end
    frame(30, 2);
    vsync_pulse();
  endtask

  initial begin
    test_reset();
    test_no_writes();
    test_cfg_write();
    test_pixel_count();
    test_held_across_update();
`ifdef AUTO_THRESH_EN
    test_auto();
`endif
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
